// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: widths,
// reset defaults and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 16;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0000;

  // S_FETCH: request outstanding
  // S_HOLD:  response buffered while ID is stalled
  // S_DRAIN: waiting out the response of a flushed request
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush clears it, stall freezes it, otherwise it
// takes the incoming instruction or becomes a bubble.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  logic            valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      // Without a new instruction ID has consumed the old one: insert a bubble.
      valid_q <= load;
      if (load) begin
        inst_q <= load_inst;
        pc_q   <= load_pc;
      end
    end
  end

  assign valid = valid_q;
  assign inst  = valid_q ? inst_q : NOP_INST;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem request, stall buffering,
// delayed-branch redirect and flush with drain of the in-flight response.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              id_stall,
  input  logic              id_redirect,
  input  logic [XLEN-1:0]   id_redirect_pc,
  input  logic              ifid_flush,
  input  logic [XLEN-1:0]   flush_pc,
  output logic              ifid_valid,
  output logic [XLEN-1:0]   ifid_inst,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [IMM_W-1:0]  ifid_imm,
  output fetch_state_e      dbg_state
);

  // imem handshake: imem_req/imem_addr rise together and stay stable until the
  // cycle imem_ack is high; that cycle completes the request and imem_rdata is
  // consumed at its closing edge. Only one request is ever outstanding.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] drain_pc_q, drain_pc_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            ifid_load;
  logic [XLEN-1:0] load_inst;
  logic [XLEN-1:0] load_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      drain_pc_q    <= '0;
      hold_inst_q   <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      drain_pc_q    <= drain_pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    drain_pc_d    = drain_pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    ifid_load     = 1'b0;
    load_inst     = imem_rdata;
    load_pc       = pc_q;

    unique case (state_q)
      S_FETCH: begin
        if (ifid_flush) begin
          redir_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = flush_pc;
          end else begin
            // Request must stay stable until acked; remember where to restart.
            state_d    = S_DRAIN;
            drain_pc_d = flush_pc;
          end
        end else begin
          if (id_redirect) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = id_redirect_pc;
          end
          if (imem_ack) begin
            // The completing fetch is the delay slot; the target comes next.
            if (id_redirect) begin
              pc_d = id_redirect_pc;
            end else if (redir_valid_q) begin
              pc_d = redir_pc_q;
            end else begin
              pc_d = next_seq_pc(pc_q);
            end
            redir_valid_d = 1'b0;
            if (id_stall) begin
              state_d     = S_HOLD;
              hold_inst_d = imem_rdata;
              hold_pc_d   = pc_q;
            end else begin
              ifid_load = 1'b1;
            end
          end
        end
      end

      S_HOLD: begin
        if (ifid_flush) begin
          state_d       = S_FETCH;
          pc_d          = flush_pc;
          redir_valid_d = 1'b0;
        end else begin
          // pc already points past the held delay slot, so a redirect lands directly.
          if (id_redirect) begin
            pc_d = id_redirect_pc;
          end
          if (!id_stall) begin
            ifid_load = 1'b1;
            load_inst = hold_inst_q;
            load_pc   = hold_pc_q;
            state_d   = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        if (ifid_flush) begin
          drain_pc_d = flush_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
          pc_d    = ifid_flush ? flush_pc : drain_pc_q;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem_req  = !rst && (state_q != S_HOLD);
  assign imem_addr = pc_q;
  assign dbg_state = state_q;

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .stall     (id_stall),
    .flush     (ifid_flush),
    .load_inst (load_inst),
    .load_pc   (load_pc),
    .valid     (ifid_valid),
    .inst      (ifid_inst),
    .pc        (ifid_pc)
  );

  assign ifid_imm = ifid_inst[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall, redirect, flush and reset
// scenarios with immediate-assertion checks.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_redirect;
  logic [31:0] id_redirect_pc;
  logic        ifid_flush;
  logic [31:0] flush_pc;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [15:0] ifid_imm;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC (T_RESET_PC),
    .NOP_INST (T_NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .id_redirect    (id_redirect),
    .id_redirect_pc (id_redirect_pc),
    .ifid_flush     (ifid_flush),
    .flush_pc       (flush_pc),
    .ifid_valid     (ifid_valid),
    .ifid_inst      (ifid_inst),
    .ifid_pc        (ifid_pc),
    .ifid_imm       (ifid_imm),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0] ^ 16'h5A5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] a);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    chk({tag, "_pc"}, ifid_pc, a);
    chk({tag, "_inst"}, ifid_inst, inst_of(a));
    chk({tag, "_imm"}, {16'd0, ifid_imm}, {16'd0, inst_of(a) & 32'h0000_FFFF});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, "_inst"}, ifid_inst, T_NOP);
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    id_stall = 1'b0;
    id_redirect = 1'b0;
    id_redirect_pc = '0;
    ifid_flush = 1'b0;
    flush_pc = '0;

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk_empty("rst");
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_FETCH));

    // Zero-stall stream: one ack per cycle
    rst = 1'b0;
    settle();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imem_addr, 32'(4 * i));
      imem_ack = 1'b1;
      imem_rdata = inst_of(32'(4 * i));
      tick();
      chk_ifid("stream", 32'(4 * i));
    end

    // Stall while the 0x10 response arrives
    chk("stall_addr", imem_addr, 32'h10);
    imem_rdata = inst_of(32'h10);
    id_stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("hold_state", 32'(dbg_state), 32'(S_HOLD));
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk_ifid("hold_frozen", 32'h0C);
      tick();
    end
    id_stall = 1'b0;
    settle();
    chk("hold_req_last", {31'd0, imem_req}, 32'd0);
    tick();
    chk_ifid("unstall", 32'h10);
    chk("unstall_state", 32'(dbg_state), 32'(S_FETCH));
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h14);

    // Run up to the branch at 0x20
    for (int a = 32'h14; a <= 32'h20; a += 4) begin
      chk("pre_br_addr", imem_addr, 32'(a));
      imem_ack = 1'b1;
      imem_rdata = inst_of(32'(a));
      tick();
      chk_ifid("pre_br", 32'(a));
    end

    // Redirect to 0x100 while the delay slot 0x24 is outstanding
    imem_ack = 1'b0;
    id_redirect = 1'b1;
    id_redirect_pc = 32'h100;
    tick();
    id_redirect = 1'b0;
    id_redirect_pc = 32'hFFFF_FFF0;
    chk("slot_addr", imem_addr, 32'h24);
    chk("slot_req", {31'd0, imem_req}, 32'd1);
    chk_empty("slot_bubble");
    imem_ack = 1'b1;
    imem_rdata = inst_of(32'h24);
    tick();
    chk_ifid("slot", 32'h24);
    chk("target_addr", imem_addr, 32'h100);
    imem_rdata = inst_of(32'h100);
    tick();
    chk_ifid("target", 32'h100);
    chk("target_next", imem_addr, 32'h104);
    imem_rdata = inst_of(32'h104);
    tick();
    chk_ifid("target2", 32'h104);
    chk("target2_next", imem_addr, 32'h108);

    // Flush together with an ack: response discarded, restart at 0x30
    imem_rdata = inst_of(32'h108);
    ifid_flush = 1'b1;
    flush_pc = 32'h30;
    tick();
    ifid_flush = 1'b0;
    imem_ack = 1'b0;
    chk_empty("flush_ack");
    chk("flush_ack_addr", imem_addr, 32'h30);
    chk("flush_ack_state", 32'(dbg_state), 32'(S_FETCH));

    // Flush while 0x30 is in flight; ack lands two cycles later
    ifid_flush = 1'b1;
    flush_pc = 32'h180;
    tick();
    ifid_flush = 1'b0;
    flush_pc = 32'h0;
    chk("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h30);
    chk_empty("drain");
    tick();
    chk("drain_addr2", imem_addr, 32'h30);
    imem_ack = 1'b1;
    imem_rdata = inst_of(32'h30);
    tick();
    imem_ack = 1'b0;
    chk("drained_state", 32'(dbg_state), 32'(S_FETCH));
    chk("drained_addr", imem_addr, 32'h180);
    chk_empty("drained");

    // Simultaneous flush and redirect: flush target wins
    imem_ack = 1'b1;
    imem_rdata = inst_of(32'h180);
    tick();
    imem_ack = 1'b0;
    chk_ifid("fr_pre", 32'h180);
    chk("fr_pre_addr", imem_addr, 32'h184);
    id_redirect = 1'b1;
    id_redirect_pc = 32'h200;
    ifid_flush = 1'b1;
    flush_pc = 32'h240;
    tick();
    id_redirect = 1'b0;
    ifid_flush = 1'b0;
    chk("fr_state", 32'(dbg_state), 32'(S_DRAIN));
    chk("fr_addr", imem_addr, 32'h184);
    chk_empty("fr");
    imem_ack = 1'b1;
    imem_rdata = inst_of(32'h184);
    tick();
    chk("fr_restart", imem_addr, 32'h240);
    chk_empty("fr_drained");
    imem_rdata = inst_of(32'h240);
    tick();
    imem_ack = 1'b0;
    chk_ifid("fr_flush_inst", 32'h240);
    chk("fr_no_target", imem_addr, 32'h244);

    // Reset mid-request with a late ack
    rst = 1'b1;
    settle();
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    settle();
    chk("late_ack_req", {31'd0, imem_req}, 32'd0);
    chk("late_ack_state", 32'(dbg_state), 32'(S_FETCH));
    chk_empty("late_ack");
    chk("late_ack_pc", ifid_pc, 32'd0);
    rst = 1'b0;
    imem_ack = 1'b0;
    settle();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, T_RESET_PC);
    chk_empty("post_rst");
    imem_ack = 1'b1;
    imem_rdata = inst_of(T_RESET_PC);
    tick();
    imem_ack = 1'b0;
    chk_ifid("post_rst_first", T_RESET_PC);
    chk("post_rst_next", imem_addr, T_RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000, instruction value driven when IF/ID is empty.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_ack  input  1  response valid for the outstanding request; variable latency of 1 or more cycles.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack is high.
REQ-009 SHALL have port id_stall  input  1  ID cannot accept; IF/ID holds its contents.
REQ-010 SHALL have port id_redirect  input  1  one-cycle pulse: taken branch/jump accepted in ID.
REQ-011 SHALL have port id_redirect_pc  input  32  branch/jump target, valid with id_redirect.
REQ-012 SHALL have port ifid_flush  input  1  one-cycle pulse: kill IF/ID, held and in-flight fetches.
REQ-013 SHALL have port flush_pc  input  32  restart address, valid with ifid_flush.
REQ-014 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 SHALL have port ifid_inst  output  32  fetched instruction.
REQ-016 SHALL have port ifid_pc  output  32  address of ifid_inst.
REQ-017 SHALL have port ifid_imm  output  16  equal to ifid_inst[15:0]; feeds the ID immediate extender.

Function
REQ-018 SHALL implement FSM states FETCH (request outstanding), HOLD (response buffered, IF/ID stalled) and DRAIN (discarding the response of a flushed request).
REQ-019 SHALL hold imem_req high and imem_addr stable from request assertion until imem_ack.
REQ-020 In FETCH with imem_ack and id_stall low: SHALL load IF/ID with {1, imem_rdata, imem_addr} at that edge, advance pc, and present the next request in the following cycle.
REQ-021 In FETCH with imem_ack and id_stall high: SHALL capture the response into a hold buffer, drop imem_req, and enter HOLD.
REQ-022 In HOLD with id_stall low: SHALL move the buffer into IF/ID and return to FETCH with imem_req high in the next cycle.
REQ-023 While id_stall is high: SHALL keep ifid_valid, ifid_inst and ifid_pc unchanged.
REQ-024 On id_redirect: SHALL latch id_redirect_pc as the pending target; the fetch in flight or held (delay slot) SHALL still be delivered, and the next request SHALL use the target.
REQ-025 The sequential next pc SHALL be pc+4, wrapping modulo 2^32.
REQ-026 On ifid_flush: SHALL clear ifid_valid at the next edge, discard any HOLD buffer, and cancel any pending redirect.
REQ-026a On ifid_flush with a request outstanding without ack: SHALL enter DRAIN, keep the request stable until ack, and discard that response.
REQ-026b In DRAIN on ack, or on ifid_flush with no request outstanding: SHALL fetch flush_pc next.
REQ-027 ifid_flush and imem_ack in the same cycle: SHALL discard the response and fetch flush_pc next.
REQ-028 Priority SHALL be ifid_flush > id_redirect > sequential pc+4.
REQ-029 When ifid_valid is 0: SHALL drive ifid_inst as NOP_INST.

Reset
REQ-030 While rst is high: SHALL hold imem_req=0, state=FETCH, pc=RESET_PC, ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=0, with no pending redirect.
REQ-031 In the first cycle after rst falls: SHALL present imem_req=1 with imem_addr=RESET_PC.
REQ-032 rst asserted mid-request: SHALL abandon the request; imem_ack arriving during or after reset before a new request SHALL be ignored.

Structure
REQ-033 SHALL place the FSM state enum, RESET_PC and NOP_INST defaults, and the 32/16-bit width constants in the shared pipeline package.
REQ-034 SHALL implement the IF/ID register as a sub-module ifid_reg (load, stall, flush inputs), instantiated once.

Verification
REQ-035 Zero-stall stream: ack every 1 cycle after reset -> ifid_pc = 0, 4, 8, 12 on consecutive cycles, ifid_imm = rdata[15:0].
REQ-036 Stall: id_stall high 3 cycles while ack arrives for 0x10 -> IF/ID unchanged, imem_req low, 0x10 loaded on the first cycle id_stall is low, then 0x14 requested.
REQ-037 Redirect: branch at 0x20 with id_redirect_pc=0x100 -> delay slot 0x24 delivered, then requests 0x100, 0x104.
REQ-038 Flush in flight: ifid_flush with flush_pc=0x180 while 0x30 is outstanding and ack lands 2 cycles later -> 0x30 discarded, ifid_valid=0, next request 0x180.
REQ-039 Simultaneous flush and redirect -> flush_pc wins, redirect target never fetched.
REQ-040 Reset mid-request -> imem_req=0 during reset, late ack ignored, first request after reset at RESET_PC.
